// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage. Owns the PC, issues one-cycle requests
// to instruction memory, waits for the variable-latency response, and presents
// the fetch bundle (instr, pc_plus_4, interrupt, interrupt_mask) to IF/ID.
// Optional build macro: IF_IRQ_SYNC_EN -- irq passes through a two-flop
// synchronizer before the pending logic.
//
// state | meaning
// ISSUE | request pc this cycle (suppressed while redirect is high)
// WAIT  | one request outstanding, waiting for imem_rvalid
// VALID | bundle held for IF/ID; handoff also issues the next request
// DROP  | outstanding response is stale, discard it when it arrives
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] IRQ_VECTOR = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        irq,
   input  logic        irq_ret,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] instr,
   output logic [31:0] pc_plus_4,
   output logic        interrupt,
   output logic        interrupt_mask
);

   typedef enum logic [1:0] {ISSUE, WAIT, VALID, DROP} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] instr_q;
   logic [31:0] addr_q;
   logic        irq_pend;
   logic        mask_q;
   logic        irq_s;
   logic        handoff;
   logic        entry;
   logic        bundle_on;
   logic [31:0] seq_pc;
   logic [31:0] next_pc;

`ifdef IF_IRQ_SYNC_EN
   logic irq_meta;
   logic irq_sync;

   // two-flop synchronizer for the asynchronous interrupt line
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_meta <= 1'b0;
         irq_sync <= 1'b0;
      end else begin
         irq_meta <= irq;
         irq_sync <= irq_meta;
      end
   end

   assign irq_s = irq_sync;
`else
   assign irq_s = irq;
`endif

   // handoff / next-PC selection; redirect outranks everything via state logic
   always_comb begin
      handoff   = (state == VALID) && !stall && !redirect;
      entry     = handoff && irq_pend;
      seq_pc    = addr_q + 32'd4;
      next_pc   = entry ? IRQ_VECTOR : seq_pc;
      bundle_on = (state == VALID) && !redirect;
   end

   // request and bundle outputs; redirect kills both in the same cycle
   always_comb begin
      imem_req       = !rst && (((state == ISSUE) && !redirect) || handoff);
      imem_addr      = handoff ? next_pc : pc;
      fetch_valid    = bundle_on;
      instr          = bundle_on ? instr_q : 32'd0;
      pc_plus_4      = bundle_on ? seq_pc : 32'd0;
      interrupt      = bundle_on && irq_pend;
      interrupt_mask = mask_q;
   end

   // fetch FSM with PC, captured bundle and interrupt pending/mask state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ISSUE;
         pc       <= RESET_PC;
         instr_q  <= 32'd0;
         addr_q   <= 32'd0;
         irq_pend <= 1'b0;
         mask_q   <= 1'b0;
      end else begin
         case (state)
            ISSUE: begin
               if (redirect) pc <= redirect_pc;
               else          state <= WAIT;
            end
            WAIT: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= imem_rvalid ? ISSUE : DROP;
               end else if (imem_rvalid) begin
                  instr_q <= imem_rdata;
                  addr_q  <= pc;
                  state   <= VALID;
               end
            end
            VALID: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= ISSUE;
               end else if (handoff) begin
                  pc    <= next_pc;
                  state <= WAIT;
               end
            end
            DROP: begin
               // a redirect arriving here still retargets the post-drop fetch
               if (redirect)    pc <= redirect_pc;
               if (imem_rvalid) state <= ISSUE;
            end
            default: state <= ISSUE;
         endcase

         if (entry)                  irq_pend <= 1'b0;
         else if (irq_s && !mask_q)  irq_pend <= 1'b1;

         if (entry)        mask_q <= 1'b1;
         else if (irq_ret) mask_q <= 1'b0;
      end
   end

endmodule
